// File: rtl/pri_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc_pkg
// Description : Shared constants, FSM state type and bit-count helper for
//               the 16-to-4 serving priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pri_enc_pkg;

    localparam int N_IN   = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Number of set bits in a request vector (0..16 fits in CNT_W bits).
    function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_IN; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_enc_find.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc_find
// Description : Combinational search over the pending vector: index of the
//               highest set bit, plus "any bit set" and "exactly one bit set"
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_enc_find
    import pri_enc_pkg::*;
(
    input  logic [N_IN-1:0]   pend,
    output logic [CODE_W-1:0] idx,
    output logic              any,
    output logic              single
);

    localparam logic [N_IN-1:0] C_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pend[i]) begin
                idx = CODE_W'(i);
            end
        end
        any    = |pend;
        single = any && ((pend & (pend - C_ONE)) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/pri_encoder_16x4.sv
`default_nettype none
// ============================================================================
// Module      : pri_encoder_16x4
// Description : Accepts a 16-bit request vector and serves its set bits one
//               beat at a time, highest index first, over a valid/ready
//               output handshake. An all-zero vector yields one "none" beat.
//               Optional feature macro PRI_ENC_CNT_EN adds the pend_cnt
//               output (number of requests still pending, current included).
// Revision    : 1.0 - initial release
// ============================================================================
module pri_encoder_16x4 #(
    parameter int N_IN   = 16,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              last,
`ifdef PRI_ENC_CNT_EN
    output logic              none,
    output logic [4:0]        pend_cnt
`else
    output logic              none
`endif
);

    import pri_enc_pkg::*;

    localparam logic [N_IN-1:0] C_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pend_q, pend_d;
    logic              none_q, none_d;

    logic [CODE_W-1:0] w_find_idx;
    logic              w_find_any;
    logic              w_find_single;
    logic              w_serving;
    logic              w_beat_last;
    logic [N_IN-1:0]   w_clr_mask;

    pri_enc_find u_find (
        .pend   (pend_q),
        .idx    (w_find_idx),
        .any    (w_find_any),
        .single (w_find_single)
    );

    // Outputs depend only on state and registered pending vector.
    always_comb begin
        w_serving   = (state_q == SERVE);
        w_beat_last = w_find_single | ~w_find_any;
        w_clr_mask  = C_ONE << w_find_idx;
        in_ready    = ~w_serving & en;
        out_valid   = w_serving;
        code        = w_serving ? w_find_idx : '0;
        last        = w_serving & w_beat_last;
        none        = w_serving & none_q;
    end

    // Next-state: load on accept, clear served bit per handshake, hold on stall.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        case (state_q)
            IDLE: begin
                if (in_valid && en) begin
                    pend_d  = req;
                    none_d  = ~|req;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pend_d = pend_q & ~w_clr_mask;
                    if (w_beat_last) begin
                        pend_d  = '0;
                        none_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                pend_d  = '0;
                none_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any vector in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

`ifdef PRI_ENC_CNT_EN
    // Pending is cleared on return to IDLE, so the count reads 0 there.
    always_comb begin
        pend_cnt = popcount(pend_q);
    end
`endif

endmodule
`default_nettype wire

// File: doc/pri_encoder_16x4.md
PRI_ENCODER_16X4 -- requirements
Module: pri_encoder_16x4

Interface
REQ-001 The block SHALL have parameter N_IN, default 16, giving the request vector width; only 16 is supported.
REQ-002 The block SHALL have parameter CODE_W, default 4, giving the code width; it always equals log2(N_IN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: acceptance enable; when low, no new vector is accepted.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the req vector is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a vector.
REQ-008 The block SHALL have port req, input, 16 bits: the one-hot or multi-hot request vector; bit i means request i.
REQ-009 The block SHALL have port out_valid, output, 1 bit: code, last and none are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the current output.
REQ-011 The block SHALL have port code, output, 4 bits: the index of the highest-numbered pending request.
REQ-012 The block SHALL have port last, output, 1 bit: this beat is the final beat for the accepted vector.
REQ-013 The block SHALL have port none, output, 1 bit: the accepted vector was all zeros.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and SERVE.
REQ-015 In IDLE, in_ready SHALL equal en and out_valid SHALL be 0.
REQ-016 On an accept (IDLE and in_valid and en), pend SHALL load req and the FSM SHALL move to SERVE, with out_valid high on the next cycle (latency 1).
REQ-017 In SERVE, out_valid SHALL be 1, in_ready SHALL be 0, code SHALL be the highest set bit index of pend, and last SHALL be 1 when pend has exactly one bit set.
REQ-018 If the accepted vector is 0, the block SHALL produce a single beat with code=0, none=1 and last=1; otherwise none SHALL be 0.
REQ-019 On a handshake (out_valid and out_ready), the served bit SHALL be cleared in pend; if last=1, the FSM SHALL return to IDLE, otherwise it SHALL stay in SERVE.
REQ-020 When out_ready is low, code, last, none and pend SHALL hold their values (stall) indefinitely.
REQ-021 en and in_valid SHALL be ignored in SERVE; en SHALL never stall an output already in progress.
REQ-022 Back-to-back operation: the earliest next accept SHALL be the cycle after the last handshake, because in_ready is registered off state.
REQ-023 Outputs code, last, none and out_valid SHALL be driven from registers or from pend/state only, with no combinational path from req or in_valid.

Reset
REQ-024 Assertion of rst SHALL immediately force state=IDLE, pend=0, out_valid=0, code=0, last=0 and none=0.
REQ-025 Assertion of rst mid-SERVE SHALL abandon the vector, with no partial beats emitted after rst deasserts.
REQ-026 On the first rising edge after rst deasserts, in_ready SHALL equal en.

Configuration
REQ-027 Macro PRI_ENC_CNT_EN SHALL control the pending-count feature.
REQ-028 When PRI_ENC_CNT_EN is defined, the block SHALL add output pend_cnt (5 bits), equal to the number of set bits in pend including the current beat; it SHALL read 0 in IDLE, 16 for the first beat of 0xFFFF, and 0 after reset.
REQ-029 When PRI_ENC_CNT_EN is undefined, the pend_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package pri_enc_pkg SHALL hold the constants N_IN=16 and CODE_W=4 and the state typedef {IDLE, SERVE}.
REQ-031 Sub-module pri_enc_find (combinational) SHALL take pend[15:0] and return the highest index (4 bits), an any flag and a single flag; the top level instantiates it once.

Verification
REQ-032 Bench SHALL check: reset, then req=16'h0008 accepted with out_ready=1 -> one beat, code=3, last=1, none=0; in_ready back to 1 the next cycle.
REQ-033 Bench SHALL check: req=16'h8421 with out_ready=1 -> four beats, code=15, 10, 5, 0, with last only on code=0; with PRI_ENC_CNT_EN, pend_cnt=4, 3, 2, 1.
REQ-034 Bench SHALL check: req=16'h0000 -> one beat, code=0, none=1, last=1.
REQ-035 Bench SHALL check: req=16'h0081 with out_ready held low for 5 cycles -> code=7 stable throughout; after release, code 7 then code 0.
REQ-036 Bench SHALL check: en=0 with in_valid=1 -> in_ready=0 and no beat; then en=1 -> accepted, out_valid high on the next cycle.
REQ-037 Bench SHALL check: rst pulsed during the 2nd beat of 16'hFFFF -> out_valid=0 immediately, and no further beats after release.
